bcd_to_bin_1: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the display-path binary-to-BCD stage. It takes four packed BCD digits (0–9999), as produced by keypad or threshold entry, and returns a 14-bit binary value for the measurement and control logic. The conversion is a reverse double-dabble (shift-right / subtract-3), one bit per clock, under a start/done handshake.

---
 rtl/bcd_to_bin_1_if.sv | 23 ++
 rtl/bcd_to_bin_1.sv | 101 ++++++++++
 tb/tb_bcd_to_bin_1.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_1_if.sv
// Handshake and data bundle for the bcd_to_bin_1 converter.
// The master drives the request and BCD digits; the slave (converter) returns the result.
interface bcd_to_bin_1_if;
    logic        start;
    logic [3:0]  qian;
    logic [3:0]  bai;
    logic [3:0]  shi;
    logic [3:0]  ge;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, qian, bai, shi, ge,
        input  bin, busy, done, err
    );

    modport slave (
        input  start, qian, bai, shi, ge,
        output bin, busy, done, err
    );
endinterface

// File: rtl/bcd_to_bin_1.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble, one bit per clock).
// Define BCD_CHECK_EN to reject digits above 9 with err and a one-cycle done instead of converting.
module bcd_to_bin_1 (
    input  logic           clk_100M,
    input  logic           rst,
    bcd_to_bin_1_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef BCD_CHECK_EN
    localparam logic [1:0] FAULT = 2'd2;
`endif

    logic [1:0]  state;
    logic [15:0] bcd_r;
    logic [13:0] bin_r;
    logic [3:0]  cnt;
    logic [15:0] bcd_sh;
    logic [15:0] bcd_adj;
    logic [13:0] bin_sh;

    // Shift the combined register right, then pull each nibble that reached 8+ back by 3.
    // The correction is skipped on the final shift since bcd_r is no longer needed.
    always_comb begin
        bcd_sh  = {1'b0, bcd_r[15:1]};
        bin_sh  = {bcd_r[0], bin_r[13:1]};
        bcd_adj = bcd_sh;
        for (int i = 0; i < 4; i++) begin
            if (cnt != 4'd13 && bcd_sh[i*4+3])
                bcd_adj[i*4 +: 4] = bcd_sh[i*4 +: 4] - 4'd3;
        end
    end

`ifdef BCD_CHECK_EN
    logic bad_digit;
    assign bad_digit = (bus.qian > 4'd9) || (bus.bai > 4'd9) ||
                       (bus.shi > 4'd9) || (bus.ge > 4'd9);
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            state    <= IDLE;
            bcd_r    <= '0;
            bin_r    <= '0;
            cnt      <= '0;
            bus.bin  <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
`ifdef BCD_CHECK_EN
            bus.err  <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bcd_r <= {bus.qian, bus.bai, bus.shi, bus.ge};
                        bin_r <= '0;
                        cnt   <= '0;
`ifdef BCD_CHECK_EN
                        if (bad_digit) begin
                            bus.err <= 1'b1;
                            bus.bin <= '0;
                            state   <= FAULT;
                        end else begin
                            bus.err  <= 1'b0;
                            bus.busy <= 1'b1;
                            state    <= SHIFT;
                        end
`else
                        bus.busy <= 1'b1;
                        state    <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    bcd_r <= bcd_adj;
                    bin_r <= bin_sh;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd13) begin
                        bus.bin  <= bin_sh;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
`ifdef BCD_CHECK_EN
                FAULT: begin
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_1.sv
// Self-checking bench for bcd_to_bin_1: directed vector table, corner sequences and random digits
// checked against the decimal value 1000*qian + 100*bai + 10*shi + ge.
module tb_bcd_to_bin_1;

    logic clk_100M = 1'b0;
    logic rst;

    bcd_to_bin_1_if bus ();

    bcd_to_bin_1 dut (
        .clk_100M (clk_100M),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [3:0] q;
        logic [3:0] b;
        logic [3:0] s;
        logic [3:0] g;
        int         expect_bin;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int model(input int q, input int b, input int s, input int g);
        return 1000 * q + 100 * b + 10 * s + g;
    endfunction

    // Drives start at the current negedge, optionally re-pulses start (with other digits)
    // mid-run, and returns at the negedge on which done is seen.
    task automatic apply_stimulus(input logic [3:0] q, input logic [3:0] b,
                                  input logic [3:0] s, input logic [3:0] g,
                                  input int poke,
                                  output int got_bin, output int got_err,
                                  output int lat, output int busy_ok);
        bus.start = 1'b1;
        bus.qian  = q;
        bus.bai   = b;
        bus.shi   = s;
        bus.ge    = g;
        got_bin   = -1;
        got_err   = -1;
        lat       = -1;
        busy_ok   = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_100M);
            if (k == 1) bus.start = 1'b0;
            if (k == poke) begin
                bus.start = 1'b1;
                bus.qian  = 4'd9;
                bus.bai   = 4'd9;
                bus.shi   = 4'd9;
                bus.ge    = 4'd9;
            end
            if (poke > 0 && k == poke + 1) bus.start = 1'b0;
            if (bus.done) begin
                lat     = k - 1;
                got_bin = int'(bus.bin);
                got_err = int'(bus.err);
                if (bus.busy) busy_ok = 0;
                break;
            end
            if (!bus.busy) busy_ok = 0;
        end
    endtask

    task automatic run_valid(input string name, input int q, input int b,
                             input int s, input int g, input int expect_bin, input int poke);
        int got_bin, got_err, lat, busy_ok;
        apply_stimulus(4'(q), 4'(b), 4'(s), 4'(g), poke, got_bin, got_err, lat, busy_ok);
        check_output({name, " latency"}, lat, 14);
        check_output({name, " busy"}, busy_ok, 1);
        check_output({name, " bin"}, got_bin, expect_bin);
        check_output({name, " err"}, got_err, 0);
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_100M);
            if (bus.done) seen++;
        end
    endtask

    vec_t vecs[8];

    initial begin
        int seen;
        int got_bin, got_err, lat, busy_ok;
        int q, b, s, g;

        vecs[0] = '{4'd9, 4'd9, 4'd9, 4'd9, 9999};
        vecs[1] = '{4'd1, 4'd2, 4'd3, 4'd4, 1234};
        vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 0};
        vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd1, 1};
        vecs[4] = '{4'd8, 4'd0, 4'd0, 4'd0, 8000};
        vecs[5] = '{4'd0, 4'd0, 4'd8, 4'd8, 88};
        vecs[6] = '{4'd1, 4'd0, 4'd2, 4'd4, 1024};
        vecs[7] = '{4'd5, 4'd5, 4'd5, 4'd5, 5555};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.qian  = 4'd0;
        bus.bai   = 4'd0;
        bus.shi   = 4'd0;
        bus.ge    = 4'd0;
        repeat (3) @(negedge clk_100M);
        check_output("reset bin", int'(bus.bin), 0);
        check_output("reset busy", int'(bus.busy), 0);
        check_output("reset done", int'(bus.done), 0);
        check_output("reset err", int'(bus.err), 0);
        rst = 1'b0;
        @(negedge clk_100M);

        // Table vectors run back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 8; i++)
            run_valid($sformatf("vec%0d", i), int'(vecs[i].q), int'(vecs[i].b),
                      int'(vecs[i].s), int'(vecs[i].g), vecs[i].expect_bin, -1);

        // Start re-asserted at cycle 5 is ignored; exactly one done follows.
        run_valid("ignored start", 0, 0, 4, 2, 42, 5);
        count_done(20, seen);
        check_output("ignored start extra done", seen, 0);

        // Reset during cycle 7 of a conversion aborts it silently.
        bus.start = 1'b1;
        bus.qian  = 4'd5;
        bus.bai   = 4'd0;
        bus.shi   = 4'd0;
        bus.ge    = 4'd0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_100M);
            if (k == 1) bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk_100M);
        rst = 1'b0;
        check_output("midreset busy", int'(bus.busy), 0);
        check_output("midreset bin", int'(bus.bin), 0);
        check_output("midreset done", int'(bus.done), 0);
        count_done(20, seen);
        check_output("midreset late done", seen, 0);

`ifdef BCD_CHECK_EN
        apply_stimulus(4'd1, 4'hA, 4'd0, 4'd0, -1, got_bin, got_err, lat, busy_ok);
        check_output("invalid latency", lat, 1);
        check_output("invalid err", got_err, 1);
        check_output("invalid bin", got_bin, 0);
        check_output("invalid busy never high", busy_ok, 0);
        run_valid("after invalid", 0, 0, 0, 7, 7, -1);
`else
        apply_stimulus(4'd1, 4'hA, 4'd0, 4'd0, -1, got_bin, got_err, lat, busy_ok);
        check_output("invalid nocheck latency", lat, 14);
        check_output("invalid nocheck err", got_err, 0);
        run_valid("after invalid", 0, 0, 0, 7, 7, -1);
`endif

        // Random back-to-back conversions against the decimal model.
        for (int i = 0; i < 1500; i++) begin
            q = int'($urandom_range(0, 9));
            b = int'($urandom_range(0, 9));
            s = int'($urandom_range(0, 9));
            g = int'($urandom_range(0, 9));
            run_valid($sformatf("rand %0d%0d%0d%0d", q, b, s, g), q, b, s, g,
                      model(q, b, s, g), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
